// File: rtl/lang_card_ctrl_multi.sv
// lang_card_ctrl_multi: Apple II language-card soft-switch controller with a
// main LC switch set ($C080-$C08F) and a Saturn-style banked card in slot
// SAT_SLOT. Switch accesses are qualified by acc_stb, not by address changes.
// Optional status readback on $C011/$C012 is built when LC_STATUS_EN is defined;
// otherwise status_oe/status_d7 are tied low.
module lang_card_ctrl_multi #(
  parameter int BANK_W   = 3,
  parameter int SAT_SLOT = 5,
  localparam int RA_W    = BANK_W + 15
) (
  input  logic              mclk28,
  input  logic              reset_in,
  input  logic [15:0]       addr,
  input  logic              we,
  input  logic              acc_stb,
  output logic [RA_W-1:0]   ram_addr,
  output logic              card_ram_rd,
  output logic              card_ram_we,
  output logic              bank1,
  output logic [BANK_W-1:0] sat_bank,
  output logic              lc_hit,
  output logic              status_oe,
  output logic              status_d7
);

  localparam logic [11:0] MAIN_WIN = 12'hC08;
  localparam logic [11:0] SAT_WIN  = 12'hC08 + 12'(SAT_SLOT);

  // Main language-card switch state
  logic write_en_q, write_en_d;
  logic read_en_q, read_en_d;
  logic pre_wr_q, pre_wr_d;
  logic bank1_q, bank1_d;
  // Saturn card switch state
  logic sat_write_en_q, sat_write_en_d;
  logic sat_read_en_q, sat_read_en_d;
  logic sat_pre_wr_q, sat_pre_wr_d;
  logic bankb_q, bankb_d;
  logic [BANK_W-1:0] sat_bank_q, sat_bank_d;

  logic main_win_s, sat_win_s, def_s, dxxx_s, sat_active_s;
  logic [2:0] bank_sel_s;
  logic [15:0] main_addr_s;

  assign main_win_s   = (addr[15:4] == MAIN_WIN);
  assign sat_win_s    = (addr[15:4] == SAT_WIN);
  assign def_s        = (addr[15:14] == 2'b11) && (addr[13:12] != 2'b00);
  assign dxxx_s       = (addr[15:12] == 4'hD);
  assign sat_active_s = (sat_read_en_q | sat_write_en_q) & def_s;
  assign bank_sel_s   = {addr[3], addr[1:0]};

  // Next-state for both switch sets; odd reads arm pre_wr, a second odd read enables writes
  always_comb begin
    write_en_d     = write_en_q;
    read_en_d      = read_en_q;
    pre_wr_d       = pre_wr_q;
    bank1_d        = bank1_q;
    sat_write_en_d = sat_write_en_q;
    sat_read_en_d  = sat_read_en_q;
    sat_pre_wr_d   = sat_pre_wr_q;
    bankb_d        = bankb_q;
    sat_bank_d     = sat_bank_q;
    if (acc_stb) begin
      if (main_win_s) begin
        bank1_d   = addr[3];
        read_en_d = ~(addr[0] ^ addr[1]);
        if (!addr[0]) begin
          write_en_d = 1'b0;
          pre_wr_d   = 1'b0;
        end else if (!we) begin
          write_en_d = write_en_q | pre_wr_q;
          pre_wr_d   = 1'b1;
        end else begin
          pre_wr_d = 1'b0;
        end
      end else if (sat_win_s && !addr[2]) begin
        bankb_d       = addr[3];
        sat_read_en_d = ~(addr[0] ^ addr[1]);
        if (!addr[0]) begin
          sat_write_en_d = 1'b0;
          sat_pre_wr_d   = 1'b0;
        end else if (!we) begin
          sat_write_en_d = sat_write_en_q | sat_pre_wr_q;
          sat_pre_wr_d   = 1'b1;
        end else begin
          sat_pre_wr_d = 1'b0;
        end
      end else if (sat_win_s) begin
        sat_bank_d = bank_sel_s[BANK_W-1:0];
      end else begin
        sat_bank_d = sat_bank_q;
      end
    end else begin
      sat_bank_d = sat_bank_q;
    end
  end

  // Switch state registers; reset leaves the main card write-enabled and read-disabled
  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      write_en_q     <= 1'b1;
      read_en_q      <= 1'b0;
      pre_wr_q       <= 1'b0;
      bank1_q        <= 1'b0;
      sat_write_en_q <= 1'b0;
      sat_read_en_q  <= 1'b0;
      sat_pre_wr_q   <= 1'b0;
      bankb_q        <= 1'b0;
      sat_bank_q     <= '0;
    end else begin
      write_en_q     <= write_en_d;
      read_en_q      <= read_en_d;
      pre_wr_q       <= pre_wr_d;
      bank1_q        <= bank1_d;
      sat_write_en_q <= sat_write_en_d;
      sat_read_en_q  <= sat_read_en_d;
      sat_pre_wr_q   <= sat_pre_wr_d;
      bankb_q        <= bankb_d;
      sat_bank_q     <= sat_bank_d;
    end
  end

  assign main_addr_s = {addr[15:13], addr[12] & ~(bank1_q & dxxx_s), addr[11:0]};

  // Map $D000-$FFFF into Saturn RAM when that card is enabled, else onto the main card
  always_comb begin
    if (sat_active_s) begin
      ram_addr = {1'b1, sat_bank_q, addr[13], addr[12] & ~(bankb_q & dxxx_s), addr[11:0]};
    end else begin
      ram_addr = RA_W'(main_addr_s);
    end
  end

  assign card_ram_rd = read_en_q | sat_read_en_q;
  assign card_ram_we = write_en_q | sat_write_en_q;
  assign bank1       = bank1_q;
  assign sat_bank    = sat_bank_q;
  assign lc_hit      = def_s && (we ? card_ram_we : card_ram_rd);

`ifdef LC_STATUS_EN
  // Status readback: $C011 reports bank2 selected, $C012 reports RAM read enabled
  always_comb begin
    status_oe = acc_stb & ~we & ((addr == 16'hC011) | (addr == 16'hC012));
    if (addr == 16'hC011) begin
      status_d7 = ~bank1_q;
    end else begin
      status_d7 = card_ram_rd;
    end
  end
`else
  assign status_oe = 1'b0;
  assign status_d7 = 1'b0;
`endif

endmodule

// File: tb/tb_lang_card_ctrl_multi.sv
// Directed bench for lang_card_ctrl_multi (default BANK_W=3, SAT_SLOT=5).
module tb_lang_card_ctrl_multi;

  logic        mclk28 = 1'b0;
  logic        reset_in = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        we = 1'b0;
  logic        acc_stb = 1'b0;
  logic [17:0] ram_addr;
  logic        card_ram_rd, card_ram_we, bank1, lc_hit, status_oe, status_d7;
  logic [2:0]  sat_bank;

  int checks = 0;
  int errors = 0;

  lang_card_ctrl_multi dut (
    .mclk28(mclk28), .reset_in(reset_in), .addr(addr), .we(we), .acc_stb(acc_stb),
    .ram_addr(ram_addr), .card_ram_rd(card_ram_rd), .card_ram_we(card_ram_we),
    .bank1(bank1), .sat_bank(sat_bank), .lc_hit(lc_hit),
    .status_oe(status_oe), .status_d7(status_d7)
  );

  always #5 mclk28 = ~mclk28;

  typedef struct {
    logic        acc;
    logic        w;
    logic [15:0] a;
    logic        exp_rd;
    logic        exp_we;
    logic        exp_b1;
    logic [2:0]  exp_sb;
    logic [17:0] exp_ra;
    logic        exp_hit;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [0:NV-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs change at negedge, outputs sampled 1ns after the posedge
  task automatic drive(input logic acc, input logic w, input logic [15:0] a);
    @(negedge mclk28);
    acc_stb = acc;
    we      = w;
    addr    = a;
    @(posedge mclk28);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic rd, input logic wen, input logic b1);
    chk({tag, ".rd"}, 32'(card_ram_rd), 32'(rd));
    chk({tag, ".we"}, 32'(card_ram_we), 32'(wen));
    chk({tag, ".bank1"}, 32'(bank1), 32'(b1));
  endtask

  initial begin
    //            acc   w     addr      rd    we    b1    sb     ram_addr    hit
    tbl[0]  = '{1'b0, 1'b0, 16'hE000, 1'b0, 1'b1, 1'b0, 3'd0, 18'h0E000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'hC08B, 1'b1, 1'b1, 1'b1, 3'd0, 18'h0C08B, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'hC08B, 1'b1, 1'b1, 1'b1, 3'd0, 18'h0C08B, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'hC080, 1'b1, 1'b0, 1'b0, 3'd0, 18'h0C080, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'hC08B, 1'b1, 1'b0, 1'b1, 3'd0, 18'h0C08B, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'hC08B, 1'b1, 1'b1, 1'b1, 3'd0, 18'h0C08B, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'hC080, 1'b1, 1'b0, 1'b0, 3'd0, 18'h0C080, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'hC081, 1'b0, 1'b0, 1'b0, 3'd0, 18'h0C081, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'hC081, 1'b0, 1'b0, 1'b0, 3'd0, 18'h0C081, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'hC081, 1'b0, 1'b0, 1'b0, 3'd0, 18'h0C081, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'hC081, 1'b0, 1'b1, 1'b0, 3'd0, 18'h0C081, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'hC080, 1'b1, 1'b0, 1'b0, 3'd0, 18'h0C080, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'hC081, 1'b0, 1'b0, 1'b0, 3'd0, 18'h0C081, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'hE000, 1'b0, 1'b0, 1'b0, 3'd0, 18'h0E000, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'hC081, 1'b0, 1'b1, 1'b0, 3'd0, 18'h0C081, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 16'hE000, 1'b0, 1'b1, 1'b0, 3'd0, 18'h0E000, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 16'hC089, 1'b0, 1'b1, 1'b1, 3'd0, 18'h0C089, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 16'hD123, 1'b0, 1'b1, 1'b1, 3'd0, 18'h0C123, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 16'hC0D7, 1'b0, 1'b1, 1'b1, 3'd3, 18'h0C0D7, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 16'hC0DC, 1'b0, 1'b1, 1'b1, 3'd4, 18'h0C0DC, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 16'hC0D8, 1'b1, 1'b1, 1'b1, 3'd4, 18'h0C0D8, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 16'hC0D8, 1'b1, 1'b1, 1'b1, 3'd4, 18'h0C0D8, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 16'hD123, 1'b1, 1'b1, 1'b1, 3'd4, 18'h30123, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 16'hE456, 1'b1, 1'b1, 1'b1, 3'd4, 18'h32456, 1'b1};

    // Power-on reset, released at a negedge
    repeat (3) @(posedge mclk28);
    @(negedge mclk28);
    reset_in = 1'b0;
    #1;
    chk_state("reset", 1'b0, 1'b1, 1'b0);
    chk("reset.sat_bank", 32'(sat_bank), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].acc, tbl[i].w, tbl[i].a);
      chk_state($sformatf("vec%0d", i), tbl[i].exp_rd, tbl[i].exp_we, tbl[i].exp_b1);
      chk($sformatf("vec%0d.sat_bank", i), 32'(sat_bank), 32'(tbl[i].exp_sb));
      chk($sformatf("vec%0d.ram_addr", i), 32'(ram_addr), 32'(tbl[i].exp_ra));
      chk($sformatf("vec%0d.lc_hit", i), 32'(lc_hit), 32'(tbl[i].exp_hit));
    end

    // Same address held: only strobed cycles count as accesses
    drive(1'b1, 1'b0, 16'hC080);
    chk_state("hold.clr", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hC08B);
    chk_state("hold.arm", 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 16'hC08B);
    chk_state("hold.gap", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 16'hC080);
      chk_state($sformatf("hold.idle%0d", i), 1'b1, 1'b0, 1'b1);
    end
    drive(1'b1, 1'b0, 16'hC08B);
    chk_state("hold.second", 1'b1, 1'b1, 1'b1);

    // Arm the Saturn pre-write, then reset asynchronously mid-cycle
    drive(1'b1, 1'b0, 16'hC0DB);
    chk_state("prerst", 1'b1, 1'b1, 1'b1);
    #2;
    acc_stb  = 1'b0;
    reset_in = 1'b1;
    #1;
    chk_state("async_rst", 1'b0, 1'b1, 1'b0);
    chk("async_rst.sat_bank", 32'(sat_bank), 32'd0);
    @(negedge mclk28);
    reset_in = 1'b0;
    drive(1'b1, 1'b0, 16'hC08B);
    chk_state("postrst.c08b", 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 16'hC080);
    chk_state("postrst.c080", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hC0DB);
    chk_state("postrst.sat1", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hC0DB);
    chk_state("postrst.sat2", 1'b1, 1'b1, 1'b0);

    // Status readback on $C011 with bank1 clear
    drive(1'b1, 1'b0, 16'hC011);
`ifdef LC_STATUS_EN
    chk("status_oe", 32'(status_oe), 32'd1);
    chk("status_d7", 32'(status_d7), 32'd1);
`else
    chk("status_oe", 32'(status_oe), 32'd0);
    chk("status_d7", 32'(status_d7), 32'd0);
`endif
    chk_state("status.nochange", 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
